// File: rtl/fa_if.sv
// Operand/result bundle for the registered full adder.
// The master drives operands and consumes results; the slave is the adder.
interface fa_if;
    logic a;
    logic b;
    logic cin;
    logic chain;
    logic in_valid;
    logic sum;
    logic cout;
    logic out_valid;

    modport master (
        output a, b, cin, chain, in_valid,
        input  sum, cout, out_valid
    );

    modport slave (
        input  a, b, cin, chain, in_valid,
        output sum, cout, out_valid
    );
endinterface

// File: rtl/fa.sv
// Registered 1-bit full adder with an optional internal carry loop for
// LSB-first bit-serial addition. One-cycle latency, one operand per cycle.
module fa #(
    parameter bit SERIAL_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    fa_if.slave bus
);

    logic sum_q, cout_q, valid_q, carry_q;
    logic cin_eff, sum_d, cout_d;

    // In chain mode the previous carry-out feeds back in place of cin.
    always_comb begin
        cin_eff = (SERIAL_EN && bus.chain) ? carry_q : bus.cin;
        sum_d   = bus.a ^ bus.b ^ cin_eff;
        cout_d  = (bus.a & bus.b) | (bus.a & cin_eff) | (bus.b & cin_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= 1'b0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.in_valid) begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= cout_d;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_fa.sv
// Scoreboard bench for fa: a serial-enabled and a serial-disabled instance
// share the same stimulus; expected {cout,sum} are queued at drive time.
module tb_fa;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fa_if bus_s ();
    fa_if bus_p ();

    fa #(.SERIAL_EN(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    fa #(.SERIAL_EN(1'b0)) dut_p (.clk(clk), .rst(rst), .bus(bus_p));

    int nvec = 0;
    int nmis = 0;

    logic [1:0] q_s[$];
    logic [1:0] q_p[$];
    logic [1:0] hold_s, hold_p;
    logic       carry_s, carry_p;
    logic       vld_exp;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Compare one instance's outputs against its queue / held model value.
    task automatic observe(input string tag, input logic ov, input logic [1:0] res,
                           input bit serial);
        logic [1:0] exp;
        check({tag, " out_valid"}, {1'b0, ov}, {1'b0, vld_exp});
        if (ov) begin
            if (serial ? (q_s.size() == 0) : (q_p.size() == 0)) begin
                check({tag, " unexpected result"}, 2'b01, 2'b00);
            end else begin
                exp = serial ? q_s.pop_front() : q_p.pop_front();
                check({tag, " result"}, res, exp);
            end
        end else begin
            check({tag, " held"}, res, serial ? hold_s : hold_p);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic a, input logic b,
                         input logic cin, input logic chain, input string tag);
        logic [1:0] res;
        logic       ce;
        rst = r;
        bus_s.in_valid = v; bus_s.a = a; bus_s.b = b; bus_s.cin = cin; bus_s.chain = chain;
        bus_p.in_valid = v; bus_p.a = a; bus_p.b = b; bus_p.cin = cin; bus_p.chain = chain;
        if (r) begin
            hold_s = 2'b00; hold_p = 2'b00; carry_s = 1'b0; carry_p = 1'b0; vld_exp = 1'b0;
            q_s.delete(); q_p.delete();
        end else if (v) begin
            ce  = chain ? carry_s : cin;
            res = 2'(a) + 2'(b) + 2'(ce);
            q_s.push_back(res); hold_s = res; carry_s = res[1];
            res = 2'(a) + 2'(b) + 2'(cin);
            q_p.push_back(res); hold_p = res; carry_p = res[1];
            vld_exp = 1'b1;
        end else begin
            vld_exp = 1'b0;
        end
        @(posedge clk);
        #1;
        observe({tag, " ser"}, bus_s.out_valid, {bus_s.cout, bus_s.sum}, 1'b1);
        observe({tag, " par"}, bus_p.out_valid, {bus_p.cout, bus_p.sum}, 1'b0);
    endtask

    initial begin
        logic [2:0] v3;
        rst = 1'b1;
        bus_s.in_valid = 1'b0; bus_p.in_valid = 1'b0;
        @(negedge clk);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "reset_discard");

        // Exhaustive truth table, chain off.
        for (int i = 0; i < 8; i++) begin
            v3 = 3'(i);
            drive(1'b0, 1'b1, v3[2], v3[1], v3[0], 1'b0, $sformatf("tt%0d", i));
        end

        // 3 + 1 LSB first.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "ser_b0");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "ser_b1");

        // Hold with don't-care operands while idle.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "hold_load");
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'bx, 1'bx, 1'bx, 1'bx, "hold");

        // Reset mid-stream clears the carry register.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "pre_rst");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "mid_rst");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "chain_after_rst");

        // Carry-generating add then chained 0+0: only SERIAL_EN=1 sees the carry.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "gen");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "chain_gen");

        for (int i = 0; i < 80; i++) begin
            v3 = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), v3[2], v3[1],
                  v3[0], 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
